// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI part router: status nibbles,
// FSM state enums, the note message and per-part configuration records.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PRG      = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    typedef enum logic [2:0] {IDLE, D1, D2, SKIP1, SKIP2} parse_state_t;
    typedef enum logic [1:0] {E_IDLE, SCAN, OUT} emit_state_t;

    typedef struct packed {
        logic       on;
        logic [3:0] ch;
        logic [6:0] key;
        logic [6:0] vel;
    } midi_note_t;

    typedef struct packed {
        logic       en;
        logic [3:0] ch;
        logic [6:0] key_lo;
        logic [6:0] key_hi;
        logic [7:0] transpose;
    } part_cfg_t;

    localparam part_cfg_t PART_RESET = '{en: 1'b0, ch: 4'h0, key_lo: 7'h00,
                                         key_hi: 7'h7F, transpose: 8'h00};

    // Number of bits needed to represent value itself (clogb2(4) == 3).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        for (r = 0; v > 0; r++) v = v >> 1;
        return r;
    endfunction

    function automatic logic [6:0] sat_transpose(input logic [6:0] key, input logic [7:0] tr);
        logic signed [8:0] sum;
        sum = $signed({2'b00, key}) + $signed({tr[7], tr});
        if (sum < 9'sd0)
            return 7'h00;
        else if (sum > 9'sd127)
            return 7'h7F;
        else
            return sum[6:0];
    endfunction

endpackage

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser with running status; reports completed note on/off
// messages with a combinational done strobe in the cycle the last byte arrives.
module midi_note_parser
    import midi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output midi_note_t note,
    output logic       done
);

    parse_state_t state;
    logic         rs_valid;
    logic [3:0]   rs_status;
    logic [3:0]   rs_ch;
    logic [6:0]   key;

    // NOTE: done/note are combinational so the pending register can load on the
    // very edge that accepts the final data byte.
    always_comb begin
        done     = midi_valid && !midi_byte[7] && (state == D2);
        note.on  = (rs_status == NOTE_ON) && (midi_byte[6:0] != 7'h00);
        note.ch  = rs_ch;
        note.key = key;
        note.vel = midi_byte[6:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rs_valid  <= 1'b0;
            rs_status <= 4'h0;
            rs_ch     <= 4'h0;
            key       <= 7'h00;
        end else if (midi_valid && midi_byte < 8'hF8) begin
            if (midi_byte[7:4] == 4'hF) begin
                rs_valid <= 1'b0;
                state    <= IDLE;
            end else if (midi_byte[7]) begin
                rs_valid  <= 1'b1;
                rs_status <= midi_byte[7:4];
                rs_ch     <= midi_byte[3:0];
                case (midi_byte[7:4])
                    NOTE_OFF, NOTE_ON:  state <= D1;
                    PRG, CH_AT:         state <= SKIP1;
                    POLY_AT, CC, PITCH: state <= SKIP2;
                    default:            state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        // Running status: treat the byte as the first data byte.
                        if (rs_valid) begin
                            case (rs_status)
                                NOTE_OFF, NOTE_ON: begin
                                    key   <= midi_byte[6:0];
                                    state <= D2;
                                end
                                POLY_AT, CC, PITCH: state <= SKIP1;
                                default:            state <= IDLE;
                            endcase
                        end
                    end
                    D1: begin
                        key   <= midi_byte[6:0];
                        state <= D2;
                    end
                    D2:      state <= IDLE;
                    SKIP2:   state <= SKIP1;
                    SKIP1:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_part_router.sv
// Multitimbral MIDI router: CPU-programmed part slots, a one-deep pending
// message register and an emitter that fans each note out to matching parts.
module midi_part_router
    import midi_pkg::*;
#(
    parameter int PARTS   = 4,
    parameter int P_WIDTH = clogb2(PARTS),
    parameter int ADDR_W  = P_WIDTH + 2
) (
    input  logic               data_clk,
    input  logic               reset_reg_N,
    input  logic               cpu_sel,
    input  logic               cpu_write,
    input  logic               cpu_read,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    input  logic [7:0]         midi_byte,
    input  logic               midi_valid,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic               ev_note_on,
    output logic [P_WIDTH-1:0] ev_part,
    output logic [6:0]         ev_key,
    output logic [6:0]         ev_vel,
    output logic               ev_drop
);

    localparam logic [P_WIDTH-1:0] LAST = P_WIDTH'(PARTS - 1);

    part_cfg_t          parts [PARTS];
    logic [7:0]         drop_cnt;
    logic [P_WIDTH-1:0] reg_part;
    logic [1:0]         reg_field;
    logic [7:0]         rd_val;

    midi_note_t  note;
    logic        note_done;
    midi_note_t  pend_msg;
    logic        pend_full;
    logic        take;

    emit_state_t        e_state;
    midi_note_t         e_msg;
    logic [P_WIDTH-1:0] idx;
    part_cfg_t          cur;
    logic               match;
    logic [6:0]         tkey;

    midi_note_parser u_parser (
        .clk        (data_clk),
        .rst_n      (reset_reg_N),
        .midi_byte  (midi_byte),
        .midi_valid (midi_valid),
        .note       (note),
        .done       (note_done)
    );

    assign reg_part  = cpu_addr[ADDR_W-1:2];
    assign reg_field = cpu_addr[1:0];

    always_comb begin
        rd_val = drop_cnt;
        for (int p = 0; p < PARTS; p++) begin
            if (reg_part == P_WIDTH'(p)) begin
                case (reg_field)
                    2'd0: rd_val = {parts[p].en, 3'b000, parts[p].ch};
                    2'd1: rd_val = {1'b0, parts[p].key_lo};
                    2'd2: rd_val = {1'b0, parts[p].key_hi};
                    2'd3: rd_val = parts[p].transpose;
                endcase
            end
        end
    end

    // NOTE: the part table is a handful of config flops, so it is reset like any
    // other state; it must come up as "all parts disabled, full key range".
    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int p = 0; p < PARTS; p++) parts[p] <= PART_RESET;
            cpu_rdata <= 8'h00;
        end else begin
            if (cpu_sel && cpu_read) cpu_rdata <= rd_val;
            for (int p = 0; p < PARTS; p++) begin
                if (cpu_sel && cpu_write && reg_part == P_WIDTH'(p)) begin
                    case (reg_field)
                        2'd0: begin
                            parts[p].en <= cpu_wdata[7];
                            parts[p].ch <= cpu_wdata[3:0];
                        end
                        2'd1: parts[p].key_lo    <= cpu_wdata[6:0];
                        2'd2: parts[p].key_hi    <= cpu_wdata[6:0];
                        2'd3: parts[p].transpose <= cpu_wdata;
                    endcase
                end
            end
        end
    end

    assign take = (e_state == E_IDLE) && pend_full;

    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            pend_full <= 1'b0;
            pend_msg  <= '0;
            drop_cnt  <= 8'h00;
            ev_drop   <= 1'b0;
        end else begin
            ev_drop <= 1'b0;
            if (note_done) begin
                if (pend_full && !take) begin
                    ev_drop <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    pend_full <= 1'b1;
                    pend_msg  <= note;
                end
            end else if (take) begin
                pend_full <= 1'b0;
            end
        end
    end

    always_comb begin
        cur = parts[0];
        for (int p = 1; p < PARTS; p++)
            if (idx == P_WIDTH'(p)) cur = parts[p];
        match = cur.en && (cur.ch == e_msg.ch) &&
                (cur.key_lo <= e_msg.key) && (e_msg.key <= cur.key_hi);
        tkey  = sat_transpose(e_msg.key, cur.transpose);
    end

    always_ff @(posedge data_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            e_state    <= E_IDLE;
            e_msg      <= '0;
            idx        <= '0;
            ev_valid   <= 1'b0;
            ev_note_on <= 1'b0;
            ev_part    <= '0;
            ev_key     <= 7'h00;
            ev_vel     <= 7'h00;
        end else begin
            case (e_state)
                E_IDLE: begin
                    if (pend_full) begin
                        e_msg   <= pend_msg;
                        idx     <= '0;
                        e_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (match) begin
                        ev_valid   <= 1'b1;
                        ev_note_on <= e_msg.on;
                        ev_part    <= idx;
                        ev_key     <= tkey;
                        ev_vel     <= e_msg.vel;
                        e_state    <= OUT;
                    end else if (idx == LAST) begin
                        e_state <= E_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        if (idx == LAST) begin
                            e_state <= E_IDLE;
                        end else begin
                            idx     <= idx + 1'b1;
                            e_state <= SCAN;
                        end
                    end
                end
                default: e_state <= E_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_part_router.sv
// Directed bench for midi_part_router: register map, latency, fan-out,
// running status, overflow, filtering, saturation and mid-run reset.
module tb_midi_part_router;

    logic       data_clk = 1'b0;
    logic       reset_reg_N;
    logic       cpu_sel, cpu_write, cpu_read;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic [7:0] midi_byte;
    logic       midi_valid;
    logic       ev_valid, ev_ready, ev_note_on, ev_drop;
    logic [2:0] ev_part;
    logic [6:0] ev_key, ev_vel;

    int vectors = 0;
    int fails   = 0;
    int drop_pulses = 0;
    int drop_base;
    logic [7:0] rd;

    midi_part_router dut (
        .data_clk    (data_clk),
        .reset_reg_N (reset_reg_N),
        .cpu_sel     (cpu_sel),
        .cpu_write   (cpu_write),
        .cpu_read    (cpu_read),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .midi_byte   (midi_byte),
        .midi_valid  (midi_valid),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_note_on  (ev_note_on),
        .ev_part     (ev_part),
        .ev_key      (ev_key),
        .ev_vel      (ev_vel),
        .ev_drop     (ev_drop)
    );

    always #5 data_clk = ~data_clk;

    always @(negedge data_clk) if (ev_drop) drop_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge data_clk);
        cpu_sel = 1'b1; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge data_clk);
        cpu_sel = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [4:0] a, output logic [7:0] d);
        @(negedge data_clk);
        cpu_sel = 1'b1; cpu_read = 1'b1; cpu_addr = a;
        @(negedge data_clk);
        cpu_sel = 1'b0; cpu_read = 1'b0;
        d = cpu_rdata;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge data_clk);
        midi_byte = b; midi_valid = 1'b1;
        @(negedge data_clk);
        midi_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a); send(b); send(c);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ev_valid && n < 20) begin
            @(negedge data_clk);
            n++;
        end
        check({tag, ".valid"}, ev_valid, 1);
    endtask

    task automatic take_ev(input string tag, input logic on, input logic [2:0] part,
                           input logic [6:0] key, input logic [6:0] vel);
        wait_valid(tag);
        check({tag, ".on"},   ev_note_on, on);
        check({tag, ".part"}, ev_part, part);
        check({tag, ".key"},  ev_key, key);
        check({tag, ".vel"},  ev_vel, vel);
        ev_ready = 1'b1;
        @(negedge data_clk);
        ev_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        repeat (cycles) @(negedge data_clk);
        check(tag, ev_valid, 0);
    endtask

    initial begin
        reset_reg_N = 1'b0;
        cpu_sel = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        midi_byte = '0; midi_valid = 1'b0; ev_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge data_clk);
        check("rst.ev_valid", ev_valid, 0);
        check("rst.ev_drop", ev_drop, 0);
        check("rst.rdata", cpu_rdata, 8'h00);
        reset_reg_N = 1'b1;
        cpu_rd(5'd2, rd);  check("rst.key_hi0", rd, 8'h7F);
        cpu_rd(5'd0, rd);  check("rst.cfg0", rd, 8'h00);
        cpu_rd(5'd16, rd); check("rst.drop_cnt", rd, 8'h00);

        // Single part, transpose +12, latency t+2
        cpu_wr(5'd0, 8'h80);
        cpu_wr(5'd3, 8'h0C);
        cpu_rd(5'd0, rd); check("rb.cfg0", rd, 8'h80);
        cpu_rd(5'd3, rd); check("rb.tr0", rd, 8'h0C);
        send3(8'h90, 8'h3C, 8'h64);
        check("lat.t0", ev_valid, 0);
        @(negedge data_clk); check("lat.t1", ev_valid, 0);
        @(negedge data_clk); check("lat.t2", ev_valid, 1);
        take_ev("basic", 1'b1, 3'd0, 7'h48, 7'h64);
        expect_quiet("basic.single", 8);

        // Fan-out to parts 0 and 2 with back-pressure, negative saturation
        cpu_wr(5'd0, 8'h83);
        cpu_wr(5'd8, 8'h83);
        cpu_wr(5'd11, 8'h9C);
        send3(8'h93, 8'h10, 8'h40);
        wait_valid("fan.p0");
        repeat (5) begin
            @(negedge data_clk);
            check("fan.hold.valid", ev_valid, 1);
            check("fan.hold.part", ev_part, 3'd0);
            check("fan.hold.key", ev_key, 7'h1C);
        end
        take_ev("fan.p0", 1'b1, 3'd0, 7'h1C, 7'h40);
        take_ev("fan.p2", 1'b1, 3'd2, 7'h00, 7'h40);
        expect_quiet("fan.end", 8);

        // Running status with a realtime byte interleaved
        cpu_wr(5'd0, 8'h80);
        cpu_wr(5'd3, 8'h00);
        cpu_wr(5'd8, 8'h00);
        drop_base = drop_pulses;
        send3(8'h90, 8'h40, 8'h7F);
        send3(8'hF8, 8'h41, 8'h00);
        take_ev("rs.first", 1'b1, 3'd0, 7'h40, 7'h7F);
        take_ev("rs.second", 1'b0, 3'd0, 7'h41, 7'h00);
        expect_quiet("rs.end", 8);
        check("rs.no_drop", drop_pulses - drop_base, 0);

        // Overflow: third message is discarded
        drop_base = drop_pulses;
        send3(8'h90, 8'h40, 8'h40);
        send3(8'h90, 8'h41, 8'h40);
        send3(8'h90, 8'h42, 8'h40);
        @(negedge data_clk);
        check("ovf.drop_pulses", drop_pulses - drop_base, 1);
        cpu_rd(5'd16, rd); check("ovf.drop_cnt", rd, 8'h01);
        take_ev("ovf.a", 1'b1, 3'd0, 7'h40, 7'h40);
        take_ev("ovf.b", 1'b1, 3'd0, 7'h41, 7'h40);
        expect_quiet("ovf.end", 8);
        cpu_wr(5'd16, 8'h55);
        cpu_rd(5'd16, rd); check("ovf.wr_ignored", rd, 8'h01);
        cpu_rd(5'd0, rd);  check("ovf.cfg0_intact", rd, 8'h80);

        // Filtering: out-of-range key, CC and program change are silent
        cpu_wr(5'd1, 8'h30);
        cpu_wr(5'd2, 8'h40);
        send3(8'h90, 8'h20, 8'h40);
        send3(8'hB0, 8'h07, 8'h7F);
        send(8'hC0);
        send(8'h05);
        expect_quiet("filt.quiet", 8);
        send3(8'h90, 8'h35, 8'h10);
        take_ev("filt.in_range", 1'b1, 3'd0, 7'h35, 7'h10);

        // Inverted range never matches; then positive saturation
        cpu_wr(5'd1, 8'h50);
        send3(8'h90, 8'h45, 8'h10);
        expect_quiet("inv.quiet", 8);
        cpu_wr(5'd1, 8'h00);
        cpu_wr(5'd2, 8'h7F);
        cpu_wr(5'd3, 8'h7F);
        send3(8'h90, 8'h05, 8'h05);
        take_ev("sat.hi", 1'b1, 3'd0, 7'h7F, 7'h05);

        // Reset in the middle of an emitted event
        cpu_wr(5'd3, 8'h00);
        send3(8'h90, 8'h30, 8'h30);
        wait_valid("mid.pre");
        drop_base = drop_pulses;
        reset_reg_N = 1'b0;
        #1;
        check("mid.ev_valid", ev_valid, 0);
        check("mid.rdata", cpu_rdata, 8'h00);
        @(negedge data_clk);
        reset_reg_N = 1'b1;
        cpu_rd(5'd0, rd);  check("mid.cfg0", rd, 8'h00);
        cpu_rd(5'd16, rd); check("mid.drop_cnt", rd, 8'h00);
        check("mid.no_drop", drop_pulses - drop_base, 0);
        expect_quiet("mid.quiet", 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
